regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file: the synchronous successor of the processor's 8x8 register block. It holds `DEPTH` general registers of `DATA_W` bits and provides `NUM_RD` registered read ports, one write port with write-to-read bypass, and a per-register pending scoreboard for in-flight results. It sits between decode (reads, reservations) and writeback (writes) in the processor datapath.

## Interface
- `DATA_W`, 8, register width in bits
- `ADDR_W`, 3, address width; `DEPTH` = 2**`ADDR_W`
- `NUM_RD`, 2, number of read ports (1..4)
- `RST_R0`, 8'h04, reset value of r0; all other registers except r1 reset to 0
- `RST_R1`, 8'h03, reset value of r1
- `clk`  in  1  clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rd_en`  in  NUM_RD  per-port read request
- `rd_addr`  in  NUM_RD*ADDR_W  port p is at bits [p*ADDR_W +: ADDR_W]
- `rd_data`  out  NUM_RD*DATA_W  port p is at bits [p*DATA_W +: DATA_W]; registered
- `rd_valid`  out  NUM_RD  registered; high one cycle after an accepted `rd_en`
- `rd_pend`  out  NUM_RD  registered; the read target was still reserved, so the data is stale
- `wr_en`  in  1  write strobe
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `lock_en`  in  1  reserve a register for a future write
- `lock_addr`  in  ADDR_W  register to reserve
- `pend_vec`  out  DEPTH  current scoreboard bits; registered state, no combinational path

## Operation
- Storage: `DEPTH` x `DATA_W` flops. There is no hardwired zero register.
- Write: when `wr_en` is high, `wr_data` goes into r[`wr_addr`] at the edge and clears `pend_vec`[`wr_addr`].
- Read, per port p with `rd_en`[p] high:
  - Next cycle, `rd_data`[p] = r[`rd_addr`[p]].
  - Bypass: if a write to the same address occurs in the request cycle, `rd_data`[p] = `wr_data` (write-first).
  - When `rd_en`[p] is low, `rd_data`[p] holds its previous value and `rd_valid`[p] = 0.
- `rd_pend`[p]: the scoreboard bit of the target after this cycle's write clear and before this cycle's lock set.
- Lock: when `lock_en` is high, `pend_vec`[`lock_addr`] is set at the edge.
- Write and lock to the same address in one cycle: data is written and the pending bit ends at 1 (the new reservation wins).
- Multiple ports reading the same address are legal and return identical data.
- Writing a register whose pending bit is 0 is legal; the bit stays 0.
- Reset, while `rst_n` is low:
  - r0 = `RST_R0`, r1 = `RST_R1`, others 0.
  - `pend_vec` = 0, `rd_data` = 0, `rd_valid` = 0, `rd_pend` = 0.
  - Reset mid-operation drops every in-flight read and reservation.
- No `$display` in synthesizable code; debug prints belong to the bench.

## Timing
- Read latency: 1 cycle from `rd_en` to `rd_valid`/`rd_data`. Back-to-back reads on every cycle are supported on every port.
- Write takes effect at the edge. A read issued in the following cycle sees the new value through storage; a read issued in the same cycle sees it through the bypass.
- Lock is visible in `pend_vec` the cycle after `lock_en`.
- There are no stalls and no backpressure; every request is accepted.
- Reset assertion is asynchronous. Deassertion is expected synchronous to `clk`; a synchronizer is upstream.

## Structure
- Shared package `cpu_pkg`: `DATA_W`/`ADDR_W` defaults, reset constants `RST_R0`/`RST_R1`, and the register-index type.
- One sub-module, `regfile_rdport`: a single registered read port with its bypass compare and pend lookup, instantiated `NUM_RD` times in a generate loop.
- The top level owns storage, the write decoder and the scoreboard.

## Test plan
- Reset, then read r0/r1 on ports 0/1: next cycle `rd_data` = 8'h04 / 8'h03, `rd_valid` = 2'b11, `rd_pend` = 0.
- Write r5 = 8'hA7 while port 0 reads r5 in the same cycle: `rd_data`[0] = 8'hA7 next cycle (bypass). A port 1 read of r5 one cycle later also returns 8'hA7.
- Lock r3, next cycle read r3: `rd_pend` = 1 and `pend_vec`[3] = 1. Write r3 = 8'h3C with a simultaneous read of r3: `rd_pend` = 0, data 8'h3C, and `pend_vec`[3] = 0 afterwards.
- Lock and write r2 in the same cycle: r2 is updated and `pend_vec`[2] stays 1.
- Both ports read r7 every cycle for 8 cycles while writes walk r0..r7 with data 8'h10+i: `rd_valid` is continuous and data changes to 8'h17 exactly at the bypass cycle.
- Assert `rst_n` low mid-burst with `pend_vec` = 8'hFF: `rd_valid`, `rd_data` and `pend_vec` go to 0 immediately (asynchronously), and registers return to their reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared processor constants for the register file:
//           default data/address widths, reset values of r0/r1 and the
//           register-index type.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  localparam logic [DATA_W_DEF-1:0] RST_R0_DEF = 8'h04;
  localparam logic [DATA_W_DEF-1:0] RST_R1_DEF = 8'h03;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module  : regfile_rdport
// Purpose : One registered read port of the register file, with
//           write-first bypass and scoreboard (pending) lookup.
// Ports   : clk, rst_n          - clock, async active-low reset
//           en, addr            - read request and target register
//           wr_en/wr_addr/wr_data - this cycle's write, for the bypass
//           regs, pend          - storage contents and scoreboard bits
//           data, valid, pend_o - registered read result
// Rev     : 1.0 - initial release
// ============================================================================
module regfile_rdport
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0]  pend,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              pend_o
);

  logic wr_hit;

  assign wr_hit = wr_en && (wr_addr == addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data   <= '0;
      valid  <= 1'b0;
      pend_o <= 1'b0;
    end else begin
      valid <= en;
      // A same-cycle write both supplies the data and retires the
      // reservation; a same-cycle lock is deliberately not seen here.
      pend_o <= en && pend[addr] && !wr_hit;
      if (en) begin
        data <= wr_hit ? wr_data : regs[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Purpose : Multi-port register file: DEPTH x DATA_W storage, NUM_RD
//           registered read ports with write bypass, one write port and a
//           per-register pending scoreboard.
// Ports   : clk, rst_n                 - clock, async active-low reset
//           rd_en/rd_addr              - packed per-port read requests
//           rd_data/rd_valid/rd_pend   - packed per-port registered results
//           wr_en/wr_addr/wr_data      - write port (clears pending bit)
//           lock_en/lock_addr          - reserve a register (sets pending bit)
//           pend_vec                   - scoreboard state
// Rev     : 1.0 - initial release
// ============================================================================
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int                 DATA_W = DATA_W_DEF,
  parameter int                 ADDR_W = ADDR_W_DEF,
  parameter int                 NUM_RD = 2,
  parameter logic [DATA_W-1:0]  RST_R0 = RST_R0_DEF,
  parameter logic [DATA_W-1:0]  RST_R1 = RST_R1_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     lock_en,
  input  logic [ADDR_W-1:0]        lock_addr,
  output logic [(1<<ADDR_W)-1:0]   pend_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  wr_mask;
  logic [DEPTH-1:0]  lock_mask;

  always_comb begin
    wr_mask   = '0;
    lock_mask = '0;
    if (wr_en)   wr_mask[wr_addr]     = 1'b1;
    if (lock_en) lock_mask[lock_addr] = 1'b1;
  end

  // Storage: r0/r1 carry non-zero reset constants, no hardwired zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs[0] <= RST_R0;
      regs[1] <= RST_R1;
      for (int i = 2; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: clear then set, so a same-cycle lock wins over the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vec <= '0;
    end else begin
      pend_vec <= (pend_vec & ~wr_mask) | lock_mask;
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rdport
      regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_rdport (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rd_en[p]),
        .addr    (rd_addr[p*ADDR_W +: ADDR_W]),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .regs    (regs),
        .pend    (pend_vec),
        .data    (rd_data[p*DATA_W +: DATA_W]),
        .valid   (rd_valid[p]),
        .pend_o  (rd_pend[p])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_mp
// Purpose : Directed self-checking bench for regfile_mp (default params:
//           8-bit data, 8 registers, 2 read ports).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_pend;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        lock_en;
  logic [2:0]  lock_addr;
  logic [7:0]  pend_vec;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_pend   (rd_pend),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .pend_vec  (pend_vec)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 2'b00; wr_en = 1'b0; lock_en = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; lock_addr = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    cyc();
    n_checks++;
    if ({rd_data, rd_valid, rd_pend, pend_vec} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b pend=%b pend_vec=%h, want all 0",
               rd_data, rd_valid, rd_pend, pend_vec);
    end
    rst_n = 1'b1;
    cyc();
    rd_en = 2'b11; rd_addr = {3'd1, 3'd0};
    cyc();
    idle();
    n_checks++;
    if (rd_data !== 16'h0304 || rd_valid !== 2'b11 || rd_pend !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_values: got data=%h valid=%b pend=%b, want 0304/11/00",
               rd_data, rd_valid, rd_pend);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hA7;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd5};
    cyc();
    idle();
    n_checks++;
    if (rd_data[7:0] !== 8'hA7 || rd_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL bypass_p0: got data=%h valid=%b, want a7/01", rd_data[7:0], rd_valid);
    end
    rd_en = 2'b10; rd_addr = {3'd5, 3'd0};
    cyc();
    idle();
    n_checks++;
    if (rd_data !== 16'hA7A7 || rd_valid !== 2'b10) begin
      n_fail++;
      $display("FAIL storage_p1_hold_p0: got data=%h valid=%b, want a7a7/10", rd_data, rd_valid);
    end
  endtask

  task automatic test_lock();
    lock_en = 1'b1; lock_addr = 3'd3;
    cyc();
    idle();
    n_checks++;
    if (pend_vec !== 8'h08) begin
      n_fail++;
      $display("FAIL lock_visible: got pend_vec=%h, want 08", pend_vec);
    end
    rd_en = 2'b01; rd_addr = {3'd0, 3'd3};
    cyc();
    idle();
    n_checks++;
    if (rd_pend !== 2'b01 || rd_data[7:0] !== 8'h00) begin
      n_fail++;
      $display("FAIL lock_read_pend: got pend=%b data=%h, want 01/00", rd_pend, rd_data[7:0]);
    end
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h3C;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd3};
    cyc();
    idle();
    n_checks++;
    if (rd_pend !== 2'b00 || rd_data[7:0] !== 8'h3C || pend_vec !== 8'h00) begin
      n_fail++;
      $display("FAIL write_clears_pend: got pend=%b data=%h pend_vec=%h, want 00/3c/00",
               rd_pend, rd_data[7:0], pend_vec);
    end
  endtask

  task automatic test_lock_write_same();
    lock_en = 1'b1; lock_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A;
    cyc();
    idle();
    n_checks++;
    if (pend_vec !== 8'h04) begin
      n_fail++;
      $display("FAIL lock_wins: got pend_vec=%h, want 04", pend_vec);
    end
    rd_en = 2'b10; rd_addr = {3'd2, 3'd0};
    cyc();
    idle();
    n_checks++;
    if (rd_data[15:8] !== 8'h5A || rd_pend !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_write_data: got data=%h pend=%b, want 5a/10", rd_data[15:8], rd_pend);
    end
  endtask

  // r7 is still at its reset value 0 until the final walk step writes it.
  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h10 + i);
      rd_en = 2'b11; rd_addr = {3'd7, 3'd7};
      cyc();
      exp = (i == 7) ? 8'h17 : 8'h00;
      n_checks++;
      if (rd_valid !== 2'b11 || rd_data !== {exp, exp}) begin
        n_fail++;
        $display("FAIL burst_step%0d: got data=%h valid=%b, want %h%h/11",
                 i, rd_data, rd_valid, exp, exp);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      lock_en = 1'b1; lock_addr = 3'(i);
      rd_en = 2'b11; rd_addr = {3'(i), 3'(7 - i)};
      cyc();
    end
    n_checks++;
    if (pend_vec !== 8'hFF || rd_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL all_locked: got pend_vec=%h valid=%b, want ff/11", pend_vec, rd_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_valid !== 2'b00 || rd_data !== 16'h0000 || pend_vec !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b data=%h pend_vec=%h, want 00/0000/00",
               rd_valid, rd_data, pend_vec);
    end
    idle();
    cyc();
    rst_n = 1'b1;
    rd_en = 2'b11; rd_addr = {3'd1, 3'd0};
    cyc();
    n_checks++;
    if (rd_data !== 16'h0304) begin
      n_fail++;
      $display("FAIL reset_r0_r1: got data=%h, want 0304", rd_data);
    end
    rd_addr = {3'd7, 3'd5};
    cyc();
    idle();
    n_checks++;
    if (rd_data !== 16'h0000 || rd_pend !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_r5_r7: got data=%h pend=%b, want 0000/00", rd_data, rd_pend);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    test_reset();
    test_bypass();
    test_lock();
    test_lock_write_same();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
